// File: rtl/multi_port_fifo_ram_pkg.sv
// Shared helpers for the multi-port FIFO RAM: lane-prefix counting,
// wrap-aware counter addition and default geometry constants.
package fifo_pkg;

    localparam int MAX_LANES   = 8;
    localparam int DEF_ENTRIES = 16;
    localparam int DEF_PTR_W   = $clog2(DEF_ENTRIES);
    localparam int DEF_CTR_W   = DEF_PTR_W + 1;

    // Length of the run of 1s starting at bit 0; stops at the first gap.
    function automatic int unsigned prefix_len(
        input logic [MAX_LANES-1:0] v
    );
        int unsigned n;
        logic        gap;
        n   = 0;
        gap = 1'b0;
        for (int k = 0; k < MAX_LANES; k++) begin
            if (!v[k]) gap = 1'b1;
            else if (!gap) n++;
        end
        return n;
    endfunction

    // Counter addition modulo 2^w.
    function automatic logic [31:0] ctr_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned w
    );
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (a + b) & mask;
    endfunction

endpackage

// File: rtl/multi_port_fifo_ram_ptr_ctrl.sv
// Head/tail/occupancy control for the multi-port FIFO RAM.
// Optional tail rollback: MULTI_PORT_FIFO_RAM_ROLLBACK_EN.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter  int N_ENTRIES   = DEF_ENTRIES,
    parameter  int N_ENQ_PORTS = 2,
    parameter  int N_DEQ_PORTS = 2,
    localparam int PTR_WIDTH   = $clog2(N_ENTRIES),
    localparam int CTR_WIDTH   = PTR_WIDTH + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_aL_i,
    input  logic                   flush_i,
    input  logic [N_ENQ_PORTS-1:0] enq_valid_i,
    input  logic [N_DEQ_PORTS-1:0] deq_ready_i,
`ifdef MULTI_PORT_FIFO_RAM_ROLLBACK_EN
    input  logic                   rollback_valid_i,
    input  logic [CTR_WIDTH-1:0]   rollback_ctr_i,
`endif
    output logic [N_ENQ_PORTS-1:0] enq_ready_o,
    output logic [N_DEQ_PORTS-1:0] deq_valid_o,
    output logic [CTR_WIDTH-1:0]   enq_ctr_o,
    output logic [CTR_WIDTH-1:0]   deq_ctr_o,
    output logic [CTR_WIDTH-1:0]   count_o,
    output logic [CTR_WIDTH-1:0]   n_enq_o
);

    logic [CTR_WIDTH-1:0] enq_q, enq_d;
    logic [CTR_WIDTH-1:0] deq_q, deq_d;
    logic [CTR_WIDTH-1:0] cnt_q, cnt_d;
    logic [CTR_WIDTH-1:0] free_slots;
    logic [CTR_WIDTH-1:0] n_enq, n_deq;

    assign free_slots = CTR_WIDTH'(N_ENTRIES) - cnt_q;

    // Lane handshakes look only at registered occupancy.
    always_comb begin
        for (int i = 0; i < N_ENQ_PORTS; i++)
            enq_ready_o[i] = free_slots > CTR_WIDTH'(i);
        for (int i = 0; i < N_DEQ_PORTS; i++)
            deq_valid_o[i] = cnt_q > CTR_WIDTH'(i);
    end

    assign n_enq = CTR_WIDTH'(prefix_len(
        MAX_LANES'(enq_valid_i & enq_ready_o)));
    assign n_deq = CTR_WIDTH'(prefix_len(
        MAX_LANES'(deq_ready_i & deq_valid_o)));

    // Next head/tail/count; flush beats rollback beats normal advance.
    always_comb begin
        n_enq_o = n_enq;
        enq_d   = CTR_WIDTH'(ctr_add(32'(enq_q), 32'(n_enq), CTR_WIDTH));
        deq_d   = CTR_WIDTH'(ctr_add(32'(deq_q), 32'(n_deq), CTR_WIDTH));
        cnt_d   = cnt_q + n_enq - n_deq;
`ifdef MULTI_PORT_FIFO_RAM_ROLLBACK_EN
        if (rollback_valid_i) begin
            n_enq_o = '0;
            enq_d   = rollback_ctr_i;
            cnt_d   = rollback_ctr_i - deq_d;
        end
`endif
        if (flush_i) begin
            n_enq_o = '0;
            enq_d   = '0;
            deq_d   = '0;
            cnt_d   = '0;
        end
    end

    // Pointer state registers.
    always_ff @(posedge clk_i or negedge rst_aL_i) begin
        if (!rst_aL_i) begin
            enq_q <= '0;
            deq_q <= '0;
            cnt_q <= '0;
        end else begin
            enq_q <= enq_d;
            deq_q <= deq_d;
            cnt_q <= cnt_d;
        end
    end

    assign enq_ctr_o = enq_q;
    assign deq_ctr_o = deq_q;
    assign count_o   = cnt_q;

endmodule

// File: rtl/multi_port_fifo_ram.sv
// N-wide in-order FIFO over a randomly accessible entry array.
// Optional tail rollback: MULTI_PORT_FIFO_RAM_ROLLBACK_EN.
module multi_port_fifo_ram
    import fifo_pkg::*;
#(
    parameter  int ENTRY_WIDTH   = 32,
    parameter  int N_ENTRIES     = DEF_ENTRIES,
    parameter  int N_ENQ_PORTS   = 2,
    parameter  int N_DEQ_PORTS   = 2,
    parameter  int N_READ_PORTS  = 2,
    parameter  int N_WRITE_PORTS = 2,
    localparam int PTR_WIDTH     = $clog2(N_ENTRIES),
    localparam int CTR_WIDTH     = PTR_WIDTH + 1
) (
    input  logic                                     clk,
    input  logic                                     rst_aL,
    input  logic                                     flush,
    output logic [N_ENQ_PORTS-1:0]                   enq_ready,
    input  logic [N_ENQ_PORTS-1:0]                   enq_valid,
    input  logic [N_ENQ_PORTS-1:0][ENTRY_WIDTH-1:0]  enq_data,
    output logic [N_DEQ_PORTS-1:0]                   deq_valid,
    input  logic [N_DEQ_PORTS-1:0]                   deq_ready,
    output logic [N_DEQ_PORTS-1:0][ENTRY_WIDTH-1:0]  deq_data,
    input  logic [N_READ_PORTS-1:0][PTR_WIDTH-1:0]   rd_addr,
    output logic [N_READ_PORTS-1:0][ENTRY_WIDTH-1:0] rd_data,
    input  logic [N_WRITE_PORTS-1:0]                 wr_en,
    input  logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]  wr_addr,
    input  logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data,
`ifdef MULTI_PORT_FIFO_RAM_ROLLBACK_EN
    input  logic                                     rollback_valid,
    input  logic [CTR_WIDTH-1:0]                     rollback_ctr,
`endif
    output logic [CTR_WIDTH-1:0]                     enq_ctr,
    output logic [CTR_WIDTH-1:0]                     deq_ctr,
    output logic [CTR_WIDTH-1:0]                     count,
    output logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]    entry_douts
);

    logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] entries_q, entries_d;
    logic [CTR_WIDTH-1:0]                  n_enq;
    logic [PTR_WIDTH-1:0]                  enq_ptr, deq_ptr;

    fifo_ptr_ctrl #(
        .N_ENTRIES   (N_ENTRIES),
        .N_ENQ_PORTS (N_ENQ_PORTS),
        .N_DEQ_PORTS (N_DEQ_PORTS)
    ) u_ptr_ctrl (
        .clk_i            (clk),
        .rst_aL_i         (rst_aL),
        .flush_i          (flush),
        .enq_valid_i      (enq_valid),
        .deq_ready_i      (deq_ready),
`ifdef MULTI_PORT_FIFO_RAM_ROLLBACK_EN
        .rollback_valid_i (rollback_valid),
        .rollback_ctr_i   (rollback_ctr),
`endif
        .enq_ready_o      (enq_ready),
        .deq_valid_o      (deq_valid),
        .enq_ctr_o        (enq_ctr),
        .deq_ctr_o        (deq_ctr),
        .count_o          (count),
        .n_enq_o          (n_enq)
    );

    assign enq_ptr = enq_ctr[PTR_WIDTH-1:0];
    assign deq_ptr = deq_ctr[PTR_WIDTH-1:0];

    // Per-entry write select: random ports in index order, enqueue last.
    always_comb begin
        entries_d = entries_q;
        for (int p = 0; p < N_WRITE_PORTS; p++)
            if (wr_en[p] && !flush)
                entries_d[wr_addr[p]] = wr_data[p];
        for (int i = 0; i < N_ENQ_PORTS; i++)
            if (CTR_WIDTH'(i) < n_enq)
                entries_d[enq_ptr + PTR_WIDTH'(i)] = enq_data[i];
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) entries_q <= '0;
        else         entries_q <= entries_d;
    end

    // Head-relative and random-access read muxes.
    always_comb begin
        for (int i = 0; i < N_DEQ_PORTS; i++)
            deq_data[i] = entries_q[deq_ptr + PTR_WIDTH'(i)];
        for (int r = 0; r < N_READ_PORTS; r++)
            rd_data[r] = entries_q[rd_addr[r]];
    end

    assign entry_douts = entries_q;

endmodule

// File: tb/tb_multi_port_fifo_ram.sv
// Randomised bench for multi_port_fifo_ram against an array/counter model.
// Build with MULTI_PORT_FIFO_RAM_ROLLBACK_EN to cover tail rollback.
`timescale 1ns/1ps
module tb_multi_port_fifo_ram;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int NE = 2;
    localparam int ND = 2;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int PW = 4;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst_aL = 1'b1;
    logic flush;
    logic [NE-1:0] enq_ready, enq_valid;
    logic [NE-1:0][W-1:0] enq_data;
    logic [ND-1:0] deq_valid, deq_ready;
    logic [ND-1:0][W-1:0] deq_data;
    logic [NR-1:0][PW-1:0] rd_addr;
    logic [NR-1:0][W-1:0] rd_data;
    logic [NW-1:0] wr_en;
    logic [NW-1:0][PW-1:0] wr_addr;
    logic [NW-1:0][W-1:0] wr_data;
    logic [CW-1:0] enq_ctr, deq_ctr, count;
    logic [N-1:0][W-1:0] entry_douts;
`ifdef MULTI_PORT_FIFO_RAM_ROLLBACK_EN
    logic rollback_valid;
    logic [CW-1:0] rollback_ctr;
`endif

    multi_port_fifo_ram dut (
        .clk         (clk),
        .rst_aL      (rst_aL),
        .flush       (flush),
        .enq_ready   (enq_ready),
        .enq_valid   (enq_valid),
        .enq_data    (enq_data),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_data    (deq_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef MULTI_PORT_FIFO_RAM_ROLLBACK_EN
        .rollback_valid (rollback_valid),
        .rollback_ctr   (rollback_ctr),
`endif
        .enq_ctr     (enq_ctr),
        .deq_ctr     (deq_ctr),
        .count       (count),
        .entry_douts (entry_douts)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: flat entry array plus free-running head/tail mod 32.
    logic [W-1:0] m [N];
    int head, tail, cnt;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Number of leading lanes that both request and fit in 'avail'.
    function automatic int lanes_ok(input logic [1:0] req, input int avail);
        int n = 0;
        for (int k = 0; k < 2; k++)
            if (n == k && req[k] && avail > k) n++;
        return n;
    endfunction

    task automatic model_reset();
        head = 0;
        tail = 0;
        cnt  = 0;
        for (int k = 0; k < N; k++) m[k] = '0;
    endtask

    task automatic model_step();
        int ne, nd;
        if (flush) begin
            head = 0;
            tail = 0;
            cnt  = 0;
            return;
        end
        ne = lanes_ok(enq_valid, N - cnt);
        nd = lanes_ok(deq_ready, cnt);
        for (int p = 0; p < NW; p++)
            if (wr_en[p]) m[wr_addr[p]] = wr_data[p];
`ifdef MULTI_PORT_FIFO_RAM_ROLLBACK_EN
        if (rollback_valid) begin
            head = (head + nd) % 32;
            tail = int'(rollback_ctr);
            cnt  = (tail - head + 32) % 32;
            return;
        end
`endif
        for (int i = 0; i < ne; i++) m[(tail + i) % N] = enq_data[i];
        head = (head + nd) % 32;
        tail = (tail + ne) % 32;
        cnt  = cnt + ne - nd;
    endtask

    task automatic idle();
        flush     = 1'b0;
        enq_valid = '0;
        enq_data  = '0;
        deq_ready = '0;
        rd_addr   = '0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
`ifdef MULTI_PORT_FIFO_RAM_ROLLBACK_EN
        rollback_valid = 1'b0;
        rollback_ctr   = '0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_aL) model_step();
        #1;
    endtask

    task automatic compare();
        logic [1:0] er, dv;
        for (int k = 0; k < 2; k++) begin
            er[k] = (N - cnt) > k;
            dv[k] = cnt > k;
        end
        check("enq_ready", 32'(enq_ready), 32'(er));
        check("deq_valid", 32'(deq_valid), 32'(dv));
        check("count", 32'(count), 32'(cnt));
        check("enq_ctr", 32'(enq_ctr), 32'(tail));
        check("deq_ctr", 32'(deq_ctr), 32'(head));
        for (int i = 0; i < ND; i++)
            if (cnt > i)
                check("deq_data", deq_data[i], m[(head + i) % N]);
        for (int r = 0; r < NR; r++)
            check("rd_data", rd_data[r], m[rd_addr[r]]);
        for (int k = 0; k < N; k++)
            check("entry_douts", entry_douts[k], m[k]);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) compare();
    end

    initial begin
        idle();
        model_reset();
        #1 rst_aL = 1'b0;
        chk_en = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("rst count", 32'(count), 32'd0);
        check("rst enq_ready", 32'(enq_ready), 32'd3);
        check("rst deq_valid", 32'(deq_valid), 32'd0);
        check("rst enq_ctr", 32'(enq_ctr), 32'd0);
        @(posedge clk);
        #1 rst_aL = 1'b1;

        // two-lane enqueue, visible next cycle
        enq_valid   = 2'b11;
        enq_data[0] = 32'hAAAA_0001;
        enq_data[1] = 32'hBBBB_0002;
        tick();
        idle();
        @(negedge clk);
        check("t1 count", 32'(count), 32'd2);
        check("t1 deq_valid", 32'(deq_valid), 32'd3);
        check("t1 deq_data0", deq_data[0], 32'hAAAA_0001);
        check("t1 deq_data1", deq_data[1], 32'hBBBB_0002);
        check("t1 enq_ctr", 32'(enq_ctr), 32'd2);
        deq_ready = 2'b11;
        tick();
        idle();

        // fill to full, then single-lane drain frees only one slot
        for (int c = 0; c < 8; c++) begin
            enq_valid   = 2'b11;
            enq_data[0] = 32'h100 + 32'(2 * c);
            enq_data[1] = 32'h101 + 32'(2 * c);
            tick();
        end
        idle();
        @(negedge clk);
        check("full count", 32'(count), 32'd16);
        check("full enq_ready", 32'(enq_ready), 32'd0);
        enq_valid = 2'b11;
        enq_data  = {32'hF1, 32'hF0};
        deq_ready = 2'b01;
        tick();
        @(negedge clk);
        check("one free enq_ready", 32'(enq_ready), 32'd1);
        check("one free count", 32'(count), 32'd15);
        tick();
        @(negedge clk);
        check("steady enq_ready", 32'(enq_ready), 32'd1);
        check("steady count", 32'(count), 32'd15);
        idle();
        deq_ready = 2'b11;
        repeat (8) tick();
        idle();

        // gap at lane 0 blocks lane 1
        enq_valid = 2'b10;
        enq_data  = {32'hDEAD, 32'hBEEF};
        tick();
        idle();
        @(negedge clk);
        check("prefix count", 32'(count), 32'd0);
        check("prefix enq_ctr", 32'(enq_ctr), 32'd19);

        // steady 2-in/2-out across pointer wrap
        enq_valid = 2'b11;
        enq_data  = {32'h2001, 32'h2000};
        tick();
        for (int c = 0; c < 40; c++) begin
            enq_valid   = 2'b11;
            deq_ready   = 2'b11;
            enq_data[0] = 32'h3000 + 32'(2 * c);
            enq_data[1] = 32'h3001 + 32'(2 * c);
            tick();
        end
        idle();
        @(negedge clk);
        check("wrap count", 32'(count), 32'd2);
        check("wrap enq_ctr", 32'(enq_ctr), 32'd5);
        check("wrap deq_ctr", 32'(deq_ctr), 32'd3);

        // write-port priority and enqueue-over-write collision
        flush = 1'b1;
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            enq_valid = 2'b11;
            enq_data  = {32'h40 + 32'(c), 32'h50 + 32'(c)};
            tick();
        end
        idle();
        enq_valid   = 2'b01;
        enq_data[0] = 32'hE6;
        wr_en       = 2'b11;
        wr_addr     = {4'd5, 4'd5};
        wr_data     = {32'h22, 32'h11};
        tick();
        idle();
        @(negedge clk);
        check("wr prio e5", entry_douts[5], 32'h22);
        check("enq e6", entry_douts[6], 32'hE6);
        enq_valid   = 2'b01;
        enq_data[0] = 32'hE7;
        wr_en       = 2'b01;
        wr_addr[0]  = 4'd7;
        wr_data[0]  = 32'hDEAD;
        tick();
        idle();
        @(negedge clk);
        check("enq beats wr e7", entry_douts[7], 32'hE7);

        // flush with occupancy 6 and enqueue requested
        flush = 1'b1;
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            enq_valid = 2'b11;
            enq_data  = {32'h60 + 32'(c), 32'h70 + 32'(c)};
            tick();
        end
        idle();
        flush     = 1'b1;
        enq_valid = 2'b11;
        tick();
        idle();
        @(negedge clk);
        check("flush count", 32'(count), 32'd0);
        check("flush deq_valid", 32'(deq_valid), 32'd0);
        check("flush enq_ctr", 32'(enq_ctr), 32'd0);
        check("flush deq_ctr", 32'(deq_ctr), 32'd0);
        check("flush keeps data", entry_douts[0], 32'h70);
`ifdef MULTI_PORT_FIFO_RAM_ROLLBACK_EN
        for (int c = 0; c < 3; c++) begin
            enq_valid = 2'b11;
            tick();
        end
        idle();
        rollback_valid = 1'b1;
        rollback_ctr   = 5'd2;
        enq_valid      = 2'b11;
        tick();
        idle();
        @(negedge clk);
        check("rollback count", 32'(count), 32'd2);
        check("rollback enq_ctr", 32'(enq_ctr), 32'd2);
`endif

        // randomised traffic with one asynchronous reset mid-run
        for (int it = 0; it < 3000; it++) begin
            enq_valid = 2'($urandom);
            for (int i = 0; i < NE; i++) enq_data[i] = $urandom;
            deq_ready = 2'($urandom);
            for (int r = 0; r < NR; r++) rd_addr[r] = 4'($urandom);
            wr_en = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            for (int p = 0; p < NW; p++) begin
                wr_addr[p] = 4'($urandom);
                wr_data[p] = $urandom;
            end
            flush = ($urandom_range(0, 63) == 0);
`ifdef MULTI_PORT_FIFO_RAM_ROLLBACK_EN
            rollback_valid = ($urandom_range(0, 15) == 0);
            begin
                int nd;
                nd = lanes_ok(deq_ready, cnt);
                rollback_ctr = 5'((tail + 32 -
                    int'($urandom_range(0, cnt - nd))) % 32);
            end
`endif
            if (it == 1500) begin
                #2 rst_aL = 1'b0;
                model_reset();
                tick();
                tick();
                rst_aL = 1'b1;
                idle();
            end
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
